// File: rtl/fp_regfile_sb.sv
// Floating-point register file with three read ports, NaN-boxing of single-precision
// writebacks, write-to-read bypass and a per-register pending scoreboard.
module fp_regfile_sb #(
  parameter int unsigned FLEN       = 64,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic [ADDR_WIDTH-1:0] addr_A,
  input  logic [ADDR_WIDTH-1:0] addr_B,
  input  logic [ADDR_WIDTH-1:0] addr_C,
  output logic [FLEN-1:0]       data_outA,
  output logic [FLEN-1:0]       data_outB,
  output logic [FLEN-1:0]       data_outC,
  output logic                  busy_A,
  output logic                  busy_B,
  output logic                  busy_C,
  input  logic                  write_En,
  input  logic [ADDR_WIDTH-1:0] writeAddr,
  input  logic [FLEN-1:0]       data_in,
  input  logic                  write_Single,
  input  logic                  issue_En,
  input  logic [ADDR_WIDTH-1:0] issueAddr,
  input  logic                  flush,
  output logic [ADDR_WIDTH:0]   pending_count
);

  localparam int unsigned NumRegs = 2 ** ADDR_WIDTH;

  logic [FLEN-1:0]     regs_q [NumRegs];
  logic [FLEN-1:0]     regs_d [NumRegs];
  logic [NumRegs-1:0]  pending_q, pending_d;
  logic [ADDR_WIDTH:0] count_q, count_d;
  logic [FLEN-1:0]     wdata;

  // Single-precision results are NaN-boxed only when the register is wider than 32 bits.
  if (FLEN > 32) begin : g_box
    assign wdata = write_Single ? {{(FLEN - 32){1'b1}}, data_in[31:0]} : data_in;
  end else begin : g_nobox
    logic unused_single;
    assign unused_single = write_Single;
    assign wdata         = data_in;
  end

  // Read ports with same-cycle bypass from the writeback.
  always_comb begin
    data_outA = regs_q[addr_A];
    data_outB = regs_q[addr_B];
    data_outC = regs_q[addr_C];
    if (write_En && (writeAddr == addr_A)) data_outA = wdata;
    if (write_En && (writeAddr == addr_B)) data_outB = wdata;
    if (write_En && (writeAddr == addr_C)) data_outC = wdata;
  end

  // A writeback in flight releases its consumer in the same cycle.
  always_comb begin
    busy_A = pending_q[addr_A] & ~(write_En && (writeAddr == addr_A));
    busy_B = pending_q[addr_B] & ~(write_En && (writeAddr == addr_B));
    busy_C = pending_q[addr_C] & ~(write_En && (writeAddr == addr_C));
  end

  // Next array contents: only the written register changes.
  always_comb begin
    for (int i = 0; i < NumRegs; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (write_En) regs_d[writeAddr] = wdata;
  end

  // Scoreboard update: flush beats issue, issue beats a same-cycle writeback clear.
  always_comb begin
    pending_d = pending_q;
    if (flush) begin
      pending_d = '0;
    end else begin
      if (write_En) pending_d[writeAddr] = 1'b0;
      if (issue_En) pending_d[issueAddr] = 1'b1;
    end
  end

  // Popcount of the post-update vector so the registered count tracks the visible bits.
  always_comb begin
    count_d = '0;
    for (int i = 0; i < NumRegs; i++) begin
      count_d = count_d + {{ADDR_WIDTH{1'b0}}, pending_d[i]};
    end
  end

  // State registers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= '0;
      end
      pending_q <= '0;
      count_q   <= '0;
    end else begin
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= regs_d[i];
      end
      pending_q <= pending_d;
      count_q   <= count_d;
    end
  end

  assign pending_count = count_q;

endmodule

// File: tb/tb_fp_regfile_sb.sv
// Randomised and directed bench for fp_regfile_sb against an array/bit-vector model.
module tb_fp_regfile_sb;

  logic        Clk;
  logic        Rst_n;
  logic [4:0]  addr_A, addr_B, addr_C;
  logic [63:0] data_outA, data_outB, data_outC;
  logic        busy_A, busy_B, busy_C;
  logic        write_En;
  logic [4:0]  writeAddr;
  logic [63:0] data_in;
  logic        write_Single;
  logic        issue_En;
  logic [4:0]  issueAddr;
  logic        flush;
  logic [5:0]  pending_count;

  fp_regfile_sb #(
    .FLEN      (64),
    .ADDR_WIDTH(5)
  ) u_dut (
    .Clk          (Clk),
    .Rst_n        (Rst_n),
    .addr_A       (addr_A),
    .addr_B       (addr_B),
    .addr_C       (addr_C),
    .data_outA    (data_outA),
    .data_outB    (data_outB),
    .data_outC    (data_outC),
    .busy_A       (busy_A),
    .busy_B       (busy_B),
    .busy_C       (busy_C),
    .write_En     (write_En),
    .writeAddr    (writeAddr),
    .data_in      (data_in),
    .write_Single (write_Single),
    .issue_En     (issue_En),
    .issueAddr    (issueAddr),
    .flush        (flush),
    .pending_count(pending_count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference state
  logic [63:0] mem_m [32];
  logic [31:0] pend_m;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] boxed(input logic [63:0] d, input logic s);
    return s ? {32'hFFFF_FFFF, d[31:0]} : d;
  endfunction

  function automatic logic [63:0] exp_data(input logic [4:0] a);
    if (write_En && writeAddr == a) return boxed(data_in, write_Single);
    return mem_m[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    return pend_m[a] && !(write_En && writeAddr == a);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mem_m[i] = '0;
    pend_m = '0;
  endtask

  // Applies the rules in plain priority order: clear on writeback, then issue sets, flush wipes.
  task automatic model_update();
    if (write_En) begin
      mem_m[writeAddr]  = boxed(data_in, write_Single);
      pend_m[writeAddr] = 1'b0;
    end
    if (issue_En) pend_m[issueAddr] = 1'b1;
    if (flush) pend_m = '0;
  endtask

  task automatic idle();
    write_En = 0; writeAddr = 0; data_in = 0; write_Single = 0;
    issue_En = 0; issueAddr = 0; flush = 0;
  endtask

  // Caller drives inputs at the falling edge; checks comb outputs, clocks, checks the count.
  task automatic do_cycle();
    #1;
    check_eq("data_A", data_outA, exp_data(addr_A));
    check_eq("data_B", data_outB, exp_data(addr_B));
    check_eq("data_C", data_outC, exp_data(addr_C));
    check_eq("busy_A", 64'(busy_A), 64'(exp_busy(addr_A)));
    check_eq("busy_B", 64'(busy_B), 64'(exp_busy(addr_B)));
    check_eq("busy_C", 64'(busy_C), 64'(exp_busy(addr_C)));
    @(posedge Clk);
    model_update();
    #1;
    check_eq("count", 64'(pending_count), 64'($countones(pend_m)));
    @(negedge Clk);
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 32; i++) begin
      addr_A = 5'(i); addr_B = 5'(31 - i); addr_C = 5'((i + 7) % 32);
      #1;
      check_eq({tag, "_dA"}, data_outA, 64'h0);
      check_eq({tag, "_dB"}, data_outB, 64'h0);
      check_eq({tag, "_dC"}, data_outC, 64'h0);
      check_eq({tag, "_bsy"}, 64'({busy_A, busy_B, busy_C}), 64'h0);
    end
    check_eq({tag, "_cnt"}, 64'(pending_count), 64'h0);
  endtask

  initial begin
    Rst_n = 1'b0;
    idle();
    addr_A = 0; addr_B = 0; addr_C = 0;
    model_reset();
    #2;
    check_all_zero("reset");
    @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);

    // NaN-boxing of a single-precision writeback, then a plain 64-bit write
    write_En = 1; writeAddr = 3; data_in = 64'h0000_0000_3F80_0000; write_Single = 1;
    do_cycle();
    idle(); addr_A = 3;
    #1 check_eq("box_single", data_outA, 64'hFFFF_FFFF_3F80_0000);
    do_cycle();
    write_En = 1; writeAddr = 3; data_in = 64'h0000_0000_3F80_0000; write_Single = 0;
    do_cycle();
    idle(); addr_A = 3;
    #1 check_eq("box_double", data_outA, 64'h0000_0000_3F80_0000);
    do_cycle();

    // Same-cycle bypass on all three ports
    addr_A = 7; addr_B = 7; addr_C = 7;
    write_En = 1; writeAddr = 7; data_in = 64'h4010_0000_0000_0000;
    #1;
    check_eq("byp_A", data_outA, 64'h4010_0000_0000_0000);
    check_eq("byp_B", data_outB, 64'h4010_0000_0000_0000);
    check_eq("byp_C", data_outC, 64'h4010_0000_0000_0000);
    do_cycle();

    // Issue then writeback of f5
    idle(); addr_A = 5; issue_En = 1; issueAddr = 5;
    do_cycle();
    idle(); addr_A = 5;
    #1;
    check_eq("sb_busy_set", 64'(busy_A), 64'h1);
    check_eq("sb_count_1", 64'(pending_count), 64'h1);
    write_En = 1; writeAddr = 5; data_in = 64'h1234;
    #1 check_eq("sb_busy_wb", 64'(busy_A), 64'h0);
    do_cycle();
    idle();
    check_eq("sb_count_0", 64'(pending_count), 64'h0);

    // f9 pending; re-issue and writeback in the same cycle keep it pending
    issue_En = 1; issueAddr = 9;
    do_cycle();
    idle(); issue_En = 1; issueAddr = 9; write_En = 1; writeAddr = 9;
    data_in = 64'hDEAD_BEEF_0000_0009; addr_A = 9;
    do_cycle();
    idle(); addr_A = 9;
    #1;
    check_eq("iw_data", data_outA, 64'hDEAD_BEEF_0000_0009);
    check_eq("iw_busy", 64'(busy_A), 64'h1);
    check_eq("iw_count", 64'(pending_count), 64'h1);
    flush = 1; issue_En = 1; issueAddr = 2;
    do_cycle();
    idle(); addr_A = 2; addr_B = 9;
    #1;
    check_eq("flush_count", 64'(pending_count), 64'h0);
    check_eq("flush_busy", 64'({busy_A, busy_B}), 64'h0);

    // Randomised traffic
    for (int n = 0; n < 400; n++) begin
      addr_A       = 5'($urandom_range(0, 31));
      addr_B       = 5'($urandom_range(0, 31));
      addr_C       = 5'($urandom_range(0, 31));
      write_En     = 1'($urandom_range(0, 1));
      writeAddr    = ($urandom_range(0, 3) == 0) ? addr_A : 5'($urandom_range(0, 31));
      data_in      = {$urandom, $urandom};
      write_Single = 1'($urandom_range(0, 1));
      issue_En     = ($urandom_range(0, 9) < 6);
      issueAddr    = ($urandom_range(0, 3) == 0) ? writeAddr : 5'($urandom_range(0, 31));
      flush        = ($urandom_range(0, 29) == 0);
      do_cycle();
    end

    // Fill every pending bit, then reset asynchronously between edges
    idle(); flush = 1;
    do_cycle();
    for (int i = 0; i < 32; i++) begin
      idle(); issue_En = 1; issueAddr = 5'(i);
      do_cycle();
    end
    idle();
    check_eq("fill_count", 64'(pending_count), 64'd32);
    #2 Rst_n = 1'b0;
    model_reset();
    check_all_zero("midrst");
    @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_regfile_sb.md
# fp_regfile_sb

Parametrised floating-point register file with integrated scoreboard, the successor to the single-precision two-read-port FP register file. Adds a third read port for fused multiply-add (rs3), NaN-boxing of single-precision results when FLEN=64, write-to-read bypass, and per-register pending bits that are set at issue and cleared at writeback. It sits between the FP decode/issue stage, which reads operands and checks hazards, and the FP execution writeback.

## Interface
- FLEN, 64, register width in bits; legal values are 32 or 64.
- ADDR_WIDTH, 5, register address width; the file holds 2**ADDR_WIDTH registers.
- Clk  in  1  clock; all state updates on the rising edge.
- Rst_n  in  1  reset, asynchronous and active-low.
- addr_A, addr_B, addr_C  in  ADDR_WIDTH  read addresses for rs1, rs2 and rs3.
- data_outA, data_outB, data_outC  out  FLEN  combinational read data.
- busy_A, busy_B, busy_C  out  1  combinational pending status of the addressed register.
- write_En  in  1  writeback strobe.
- writeAddr  in  ADDR_WIDTH  writeback destination.
- data_in  in  FLEN  writeback data.
- write_Single  in  1  the writeback is a single-precision result and must be NaN-boxed.
- issue_En  in  1  an FP op with destination issueAddr issues this cycle.
- issueAddr  in  ADDR_WIDTH  destination of the issuing op.
- flush  in  1  synchronous clear of all pending bits (pipeline flush).
- pending_count  out  ADDR_WIDTH+1  registered count of set pending bits.

## Operation
- Storage: an array of 2**ADDR_WIDTH registers of FLEN bits each. Register f0 is an ordinary register; it is not hardwired to zero.
- Boxed write data: when FLEN=64 and write_Single=1, the stored value is {32'hFFFF_FFFF, data_in[31:0]}. Otherwise the stored value is data_in. write_Single is ignored when FLEN=32.
- Write: at a Clk edge with write_En=1, the boxed data is stored to writeAddr.
- Read: each port returns the array contents at its address. If write_En=1 and the port address equals writeAddr, the port returns the boxed write data instead (bypass).
- Pending bits: one bit per register. The next value of each bit is computed in the following priority order:
  - flush=1: all bits clear; any issue in the same cycle is ignored.
  - issue_En=1 and the register is issueAddr: bit set. This wins over a same-cycle writeback to the same register, because a new producer has taken ownership.
  - write_En=1 and the register is writeAddr: bit clear.
  - otherwise: bit holds.
- A writeback to a non-pending register is legal. It updates the data and leaves the pending bit at 0.
- busy_X = pending[addr_X] AND NOT (write_En AND writeAddr==addr_X). A writeback in flight therefore unblocks its consumer in the same cycle.
- pending_count: registered popcount of the pending vector after the update, so it always matches the pending bits that are visible in that cycle.

## Timing
- Reset (Rst_n=0, asynchronous): all registers go to 0, all pending bits go to 0, and pending_count goes to 0. As a result, data_out* and busy_* read 0 from any address while no write is active.
- If reset is asserted mid-operation, an in-flight write or issue on that edge is lost. Deassertion is synchronised externally; the first write is accepted on the first edge after release.
- Write latency is 1 cycle into the array and 0 cycles on the read ports via bypass.
- Pending bit latency: set is visible on busy_* 1 cycle after issue_En. Clear is visible on busy_* immediately through the bypass term, and in the stored bit 1 cycle later.
- pending_count changes 1 cycle after the causing event. Range is 0 to 2**ADDR_WIDTH with no wrap; the width is ADDR_WIDTH+1 for this reason.
- The block has no handshake and no stall. Every input is sampled every cycle.

## Test plan
- Reset, then read every address on all three ports -> data_out*=0, busy_*=0, pending_count=0.
- FLEN=64: write f3 with data_in=64'h0000_0000_3F80_0000 and write_Single=1; next cycle read f3 -> 64'hFFFF_FFFF_3F80_0000. Repeat with write_Single=0 -> 64'h0000_0000_3F80_0000.
- Bypass: addr_A=addr_B=addr_C=7 with write_En=1, writeAddr=7, data_in=64'h4010_0000_0000_0000 -> all three outputs show the new value in the same cycle.
- Scoreboard: issue f5 -> busy_A=1 (addr_A=5) and pending_count=1 next cycle. Writeback f5 -> busy_A=0 in the same cycle, and pending_count=0 next cycle.
- Simultaneous events: f9 pending; issue f9 and write f9 in the same cycle -> data updated, pending stays 1, count unchanged. Then flush together with issue f2 -> all pending 0, count 0.
- Fill and reset: issue all 32 registers on successive cycles -> pending_count=32. Assert Rst_n=0 between edges -> count 0 and all data 0 immediately.
